// File: rtl/sd_bus_sched.sv
// sd_bus_sched: queues one pending sector write and one pending sector read,
// waits for card initialisation, then hands the single SD SPI bus to the
// write or read engine in round-robin order. Each engine is started with a
// held pulse, watched for busy, and timed out if it never responds.

module sd_bus_sched #(
  parameter int START_HOLD = 2,
  parameter int START_TO   = 16
) (
  input  logic        clk_ref_180deg,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        wr_req_in,
  input  logic [31:0] wr_addr_in,
  output logic        wr_ack,
  output logic        wr_done,
  input  logic        rd_req_in,
  input  logic [31:0] rd_addr_in,
  output logic        rd_ack,
  output logic        rd_done,
  output logic        wr_start_en,
  output logic        rd_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [31:0] rd_sec_addr,
  input  logic        wr_busy,
  input  logic        rd_busy,
  input  logic        wr_cs,
  input  logic        wr_mosi,
  input  logic        rd_cs,
  input  logic        rd_mosi,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic [1:0]  grant,
  output logic        sched_busy,
  output logic        err_timeout
);

  localparam int CMAX = (START_TO > START_HOLD) ? START_TO : START_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          selRd_q, selRd_d;
  logic          lastRd_q, lastRd_d;

  logic          wr_pend_q, rd_pend_q;
  logic [31:0]   wr_addr_q, rd_addr_q;
  logic          wr_ack_q, rd_ack_q;
  logic          wr_done_q, wr_done_d;
  logic          rd_done_q, rd_done_d;
  logic          err_timeout_q, err_timeout_d;
  logic          wr_clr, rd_clr;
  logic          selBusy;
  logic          engActive;

  // Scheduler state, phase counter, selected engine and round-robin memory
  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      selRd_q  <= 1'b0;
      lastRd_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      selRd_q  <= selRd_d;
      lastRd_q <= lastRd_d;
    end
  end

  // Next-state logic; losing init_done overrides everything and aborts silently
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    selRd_d       = selRd_q;
    lastRd_d      = lastRd_q;
    wr_clr        = 1'b0;
    rd_clr        = 1'b0;
    wr_done_d     = 1'b0;
    rd_done_d     = 1'b0;
    err_timeout_d = 1'b0;
    selBusy       = selRd_q ? rd_busy : wr_busy;
    if (!init_done) begin
      state_d = S_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_INIT: state_d = S_IDLE;
        S_IDLE: begin
          if (wr_pend_q || rd_pend_q) begin
            selRd_d = (wr_pend_q && rd_pend_q) ? !lastRd_q : rd_pend_q;
            cnt_d   = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (cnt_q == CW'(START_HOLD - 1)) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (selBusy) begin
            state_d = S_RUN;
          end else if (cnt_q == CW'(START_TO)) begin
            err_timeout_d = 1'b1;
            wr_clr        = !selRd_q;
            rd_clr        = selRd_q;
            state_d       = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!selBusy) begin
            wr_clr    = !selRd_q;
            rd_clr    = selRd_q;
            wr_done_d = !selRd_q;
            rd_done_d = selRd_q;
            lastRd_d  = selRd_q;
            state_d   = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Outputs decoded from the registered state: grant, start pulses and SPI mux
  always_comb begin
    engActive   = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_RUN);
    grant       = engActive ? (selRd_q ? 2'b10 : 2'b01) : 2'b00;
    wr_start_en = (state_q == S_START) && !selRd_q;
    rd_start_en = (state_q == S_START) && selRd_q;
    sched_busy  = (state_q != S_IDLE) && (state_q != S_INIT);
    if (state_q == S_INIT) begin
      sd_cs   = init_cs;
      sd_mosi = init_mosi;
    end else if (grant == 2'b01) begin
      sd_cs   = wr_cs;
      sd_mosi = wr_mosi;
    end else if (grant == 2'b10) begin
      sd_cs   = rd_cs;
      sd_mosi = rd_mosi;
    end else begin
      sd_cs   = 1'b1;
      sd_mosi = 1'b1;
    end
  end

  // Request capture runs in every state; a pending side ignores new requests
  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      if (wr_req_in && !wr_pend_q) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= wr_addr_in;
        wr_ack_q  <= 1'b1;
      end else if (wr_clr) begin
        wr_pend_q <= 1'b0;
      end
      if (rd_req_in && !rd_pend_q) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= rd_addr_in;
        rd_ack_q  <= 1'b1;
      end else if (rd_clr) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  // Registered completion and timeout pulses, one cycle each
  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_done_q     <= wr_done_d;
      rd_done_q     <= rd_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign rd_ack      = rd_ack_q;
  assign wr_done     = wr_done_q;
  assign rd_done     = rd_done_q;
  assign err_timeout = err_timeout_q;
  assign wr_sec_addr = wr_addr_q;
  assign rd_sec_addr = rd_addr_q;

endmodule
